cdb_arbiter: RTL and testbench

Parametrised common-data-bus arbiter, the successor to the fixed two-producer CDB. It takes N_SRC result producers (ALU reservation station, load/store buffer, future multiplier/divider) and buffers each in a small per-source FIFO. Each cycle it broadcasts up to N_BUS results on registered bus lanes, with round-robin fairness. It sits between the execution units and every tag consumer (ROB, RS, LSB), and is squashed by the ROB flush.

---
 rtl/cdb_arbiter_pkg.sv | 14 +
 rtl/cdb_src_fifo.sv | 56 +++++
 rtl/cdb_arbiter.sv | 128 ++++++++++++
 tb/tb_cdb_arbiter.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// Shared widths and helpers for the common-data-bus arbiter.
// Tag/value defaults follow the global ROB configuration.
package cdb_arbiter_pkg;

  localparam int ROB_ID_WIDTH = 5;
  localparam int VAL_WIDTH    = 32;

  localparam int CDB_TAG_W = ROB_ID_WIDTH + 1;

  function automatic int ptr_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/cdb_src_fifo.sv
// Per-producer result FIFO: wrapping pointers plus an explicit count.
// Head is read combinationally so the arbiter sees it the same cycle.
module cdb_src_fifo
  import cdb_arbiter_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int W     = 38
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic         push,
  input  logic         pop,
  input  logic         clear,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = ptr_w(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;
  logic [W-1:0]  r_mem [DEPTH];

  // Pointer and occupancy bookkeeping; clear wins over push/pop.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (clear) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (push) r_wptr <= r_wptr + 1'b1;
      if (pop)  r_rptr <= r_rptr + 1'b1;
      if (push && !pop)
        r_cnt <= r_cnt + 1'b1;
      else if (pop && !push)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // Storage array; contents need no reset since count gates visibility.
  always_ff @(posedge clk_in) begin
    if (push && !clear) r_mem[r_wptr] <= din;
  end

  assign full  = (r_cnt == (AW+1)'(DEPTH));
  assign empty = (r_cnt == '0);
  assign head  = r_mem[r_rptr];

endmodule

// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: N_SRC buffered producers onto N_BUS lanes.
// Round-robin grant from rr_ptr, registered lane outputs, ROB flush.
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int N_SRC = 3,
  parameter int N_BUS = 2,
  parameter int DEPTH = 4,
  parameter int TAG_W = CDB_TAG_W,
  parameter int VAL_W = VAL_WIDTH
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush,
  input  logic [N_SRC-1:0]       src_valid,
  input  logic [N_SRC*TAG_W-1:0] src_tag,
  input  logic [N_SRC*VAL_W-1:0] src_val,
  output logic [N_SRC-1:0]       src_ready,
  output logic [N_BUS-1:0]       bus_valid,
  output logic [N_BUS*TAG_W-1:0] bus_tag,
  output logic [N_BUS*VAL_W-1:0] bus_val
);

  localparam int DW = TAG_W + VAL_W;
  localparam int PW = ptr_w(N_SRC);

  logic [N_SRC-1:0]       w_full;
  logic [N_SRC-1:0]       w_empty;
  logic [DW-1:0]          w_head [N_SRC];
  logic [N_SRC-1:0]       w_push;
  logic [N_SRC-1:0]       w_pop;
  logic [N_SRC-1:0]       w_grant;
  logic                   w_clear;
  logic                   w_adv;
  logic [PW-1:0]          w_last;
  logic [PW-1:0]          w_rr_nxt;
  logic [N_BUS-1:0]       w_lane_v;
  logic [N_BUS*TAG_W-1:0] w_lane_tag;
  logic [N_BUS*VAL_W-1:0] w_lane_val;

  logic [PW-1:0]          r_rr;
  logic [N_BUS-1:0]       r_bus_valid;
  logic [N_BUS*TAG_W-1:0] r_bus_tag;
  logic [N_BUS*VAL_W-1:0] r_bus_val;

  assign w_adv     = rdy_in & ~flush;
  assign w_clear   = rdy_in & flush;
  assign src_ready = {N_SRC{rst_in}} & ~w_full;
  assign w_push    = src_valid & src_ready & {N_SRC{w_adv}};
  assign w_pop     = w_grant & {N_SRC{w_adv}};

  for (genvar gi = 0; gi < N_SRC; gi++) begin : g_fifo
    cdb_src_fifo #(
      .DEPTH (DEPTH),
      .W     (DW)
    ) u_fifo (
      .clk_in (clk_in),
      .rst_in (rst_in),
      .push   (w_push[gi]),
      .pop    (w_pop[gi]),
      .clear  (w_clear),
      .din    ({src_tag[gi*TAG_W +: TAG_W],
                src_val[gi*VAL_W +: VAL_W]}),
      .full   (w_full[gi]),
      .empty  (w_empty[gi]),
      .head   (w_head[gi])
    );
  end

  // Round-robin scan over a doubled index range starting at rr_ptr.
  always_comb begin
    int n;
    n          = 0;
    w_grant    = '0;
    w_last     = '0;
    w_lane_v   = '0;
    w_lane_tag = '0;
    w_lane_val = '0;
    for (int j = 0; j < 2*N_SRC; j++) begin
      if (j >= int'(r_rr) && j < int'(r_rr) + N_SRC &&
          n < N_BUS && !w_empty[j % N_SRC]) begin
        w_grant[j % N_SRC] = 1'b1;
        w_last = PW'(j % N_SRC);
        for (int k = 0; k < N_BUS; k++) begin
          if (n == k) begin
            w_lane_v[k] = 1'b1;
            w_lane_tag[k*TAG_W +: TAG_W] =
              w_head[j % N_SRC][DW-1 -: TAG_W];
            w_lane_val[k*VAL_W +: VAL_W] =
              w_head[j % N_SRC][VAL_W-1:0];
          end
        end
        n = n + 1;
      end
    end
  end

  assign w_rr_nxt = (int'(w_last) == N_SRC - 1) ?
                    '0 : w_last + 1'b1;

  // Lane registers and fairness pointer; rdy_in low freezes both.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      r_rr        <= '0;
      r_bus_valid <= '0;
      r_bus_tag   <= '0;
      r_bus_val   <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        r_rr        <= '0;
        r_bus_valid <= '0;
        r_bus_tag   <= '0;
        r_bus_val   <= '0;
      end else begin
        if (|w_grant) r_rr <= w_rr_nxt;
        r_bus_valid <= w_lane_v;
        r_bus_tag   <= w_lane_tag;
        r_bus_val   <= w_lane_val;
      end
    end
  end

  assign bus_valid = r_bus_valid;
  assign bus_tag   = r_bus_tag;
  assign bus_val   = r_bus_val;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Scoreboard bench for cdb_arbiter: queue-based reference model
// predicts each cycle's lanes; a negedge monitor pops and compares.
module tb_cdb_arbiter;
  import cdb_arbiter_pkg::*;

  localparam int NS = 3;
  localparam int NB = 2;
  localparam int D  = 4;
  localparam int TW = 6;
  localparam int VW = 32;

  logic              clk_in;
  logic              rst_in;
  logic              rdy_in;
  logic              flush;
  logic [NS-1:0]     src_valid;
  logic [NS*TW-1:0]  src_tag;
  logic [NS*VW-1:0]  src_val;
  logic [NS-1:0]     src_ready;
  logic [NB-1:0]     bus_valid;
  logic [NB*TW-1:0]  bus_tag;
  logic [NB*VW-1:0]  bus_val;

  cdb_arbiter #(
    .N_SRC (NS),
    .N_BUS (NB),
    .DEPTH (D),
    .TAG_W (TW),
    .VAL_W (VW)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .rdy_in    (rdy_in),
    .flush     (flush),
    .src_valid (src_valid),
    .src_tag   (src_tag),
    .src_val   (src_val),
    .src_ready (src_ready),
    .bus_valid (bus_valid),
    .bus_tag   (bus_tag),
    .bus_val   (bus_val)
  );

  typedef struct {
    logic [TW-1:0] tag;
    logic [VW-1:0] val;
  } item_t;

  typedef struct {
    logic [NB-1:0]    v;
    logic [NB*TW-1:0] tag;
    logic [NB*VW-1:0] val;
  } exp_t;

  item_t         mq [NS][$];
  exp_t          expq [$];
  exp_t          last_e;
  int            rr_m;
  logic          edge_new;
  logic [NS-1:0] acc_last;
  int            vecs;
  int            errs;

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] req);
    vecs++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic exp_t zero_e();
    exp_t e;
    e.v   = '0;
    e.tag = '0;
    e.val = '0;
    return e;
  endfunction

  function automatic int pending();
    int n;
    n = 0;
    for (int s = 0; s < NS; s++) n += mq[s].size();
    return n;
  endfunction

  // Reference model: queues per source, round-robin by plain indexing.
  task automatic model_step();
    exp_t          e;
    int            n;
    int            last;
    int            s;
    logic [NS-1:0] acc;
    item_t         it;
    edge_new = 1'b0;
    acc_last = '0;
    if (!rst_in) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      expq.delete();
      rr_m   = 0;
      last_e = zero_e();
      return;
    end
    if (!rdy_in) return;
    edge_new = 1'b1;
    e = zero_e();
    if (flush) begin
      for (int i = 0; i < NS; i++) mq[i].delete();
      rr_m = 0;
      expq.push_back(e);
      return;
    end
    for (int i = 0; i < NS; i++)
      acc[i] = src_valid[i] && (mq[i].size() < D);
    n = 0;
    last = -1;
    for (int k = 0; k < NS; k++) begin
      s = (rr_m + k) % NS;
      if (n < NB && mq[s].size() > 0) begin
        it = mq[s].pop_front();
        e.v[n] = 1'b1;
        e.tag[n*TW +: TW] = it.tag;
        e.val[n*VW +: VW] = it.val;
        n++;
        last = s;
      end
    end
    if (last >= 0) rr_m = (last + 1) % NS;
    for (int i = 0; i < NS; i++) begin
      if (acc[i]) begin
        it.tag = src_tag[i*TW +: TW];
        it.val = src_val[i*VW +: VW];
        mq[i].push_back(it);
      end
    end
    acc_last = acc;
    expq.push_back(e);
  endtask

  always @(posedge clk_in) model_step();

  task automatic cmp_bus(input exp_t e, input string pre);
    chk({pre, "_valid"}, 64'(bus_valid), 64'(e.v));
    for (int k = 0; k < NB; k++) begin
      if (e.v[k]) begin
        chk($sformatf("%s_tag%0d", pre, k),
            64'(bus_tag[k*TW +: TW]), 64'(e.tag[k*TW +: TW]));
        chk($sformatf("%s_val%0d", pre, k),
            64'(bus_val[k*VW +: VW]), 64'(e.val[k*VW +: VW]));
      end
    end
  endtask

  // Monitor: new lane contents after an active edge, else held.
  always @(negedge clk_in) begin
    if (rst_in) begin
      for (int s = 0; s < NS; s++)
        chk($sformatf("src_ready%0d", s), 64'(src_ready[s]),
            64'(mq[s].size() < D));
      if (edge_new) begin
        if (expq.size() == 0) begin
          chk("exp_queue_empty", 64'(1), 64'(0));
        end else begin
          last_e = expq.pop_front();
          cmp_bus(last_e, "bus");
        end
      end else begin
        cmp_bus(last_e, "hold");
      end
    end
  end

  // Producer: keep an offered item until accepted, then maybe new one.
  task automatic drive(input int pct);
    for (int s = 0; s < NS; s++) begin
      if (!src_valid[s] || acc_last[s]) begin
        src_valid[s] = ($urandom_range(99) < pct);
        src_tag[s*TW +: TW] = TW'($urandom);
        src_val[s*VW +: VW] = $urandom;
      end
    end
  endtask

  initial begin
    vecs      = 0;
    errs      = 0;
    rr_m      = 0;
    edge_new  = 1'b0;
    acc_last  = '0;
    last_e    = zero_e();
    rst_in    = 1'b1;
    rdy_in    = 1'b1;
    flush     = 1'b0;
    src_valid = '0;
    src_tag   = '0;
    src_val   = '0;
    #1 rst_in = 1'b0;
    #1;
    chk("rst_bus_valid", 64'(bus_valid), 64'(0));
    chk("rst_bus_tag", 64'(bus_tag), 64'(0));
    chk("rst_src_ready", 64'(src_ready), 64'(0));
    repeat (2) @(negedge clk_in);
    #2 rst_in = 1'b1;

    // Single push on source 0.
    @(negedge clk_in);
    src_valid = 3'b001;
    src_tag[0 +: TW] = 6'd5;
    src_val[0 +: VW] = 32'hDEAD;
    @(negedge clk_in);
    src_valid = '0;
    @(negedge clk_in);
    chk("single_v", 64'(bus_valid), 64'(2'b01));
    chk("single_tag", 64'(bus_tag[0 +: TW]), 64'(5));
    chk("single_val", 64'(bus_val[0 +: VW]), 64'(32'hDEAD));
    repeat (3) @(negedge clk_in);

    // Saturated load: all sources push every cycle.
    for (int s = 0; s < NS; s++) begin
      src_tag[s*TW +: TW] = TW'(s + 1);
      src_val[s*VW +: VW] = $urandom;
    end
    src_valid = '1;
    for (int c = 0; c < 100; c++) begin
      @(negedge clk_in);
      drive(100);
    end

    // Flush with queued entries and live lanes.
    src_valid = '0;
    flush = 1'b1;
    @(negedge clk_in);
    flush = 1'b0;
    chk("flush_ready", 64'(src_ready), 64'(3'b111));
    repeat (3) @(negedge clk_in);

    // Stall: lanes must hold and nothing is pushed.
    src_valid = '1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk_in);
      drive(100);
    end
    rdy_in = 1'b0;
    repeat (5) @(negedge clk_in);
    rdy_in = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_in);
      drive(80);
    end

    // Asynchronous reset between edges.
    @(negedge clk_in);
    #2 rst_in = 1'b0;
    src_valid = '0;
    #1;
    chk("async_bus_valid", 64'(bus_valid), 64'(0));
    chk("async_src_ready", 64'(src_ready), 64'(0));
    @(negedge clk_in);
    #2 rst_in = 1'b1;

    // Random traffic with stalls and occasional flushes.
    for (int c = 0; c < 400; c++) begin
      @(negedge clk_in);
      drive(60);
      rdy_in = ($urandom_range(9) != 0);
      flush  = ($urandom_range(39) == 0);
    end
    @(negedge clk_in);
    rdy_in = 1'b1;
    flush = 1'b0;
    src_valid = '0;

    // Drain with a bounded wait.
    for (int i = 0; i < 50 && pending() > 0; i++)
      @(negedge clk_in);
    chk("drain_left", 64'(pending()), 64'(0));
    repeat (3) @(negedge clk_in);
    chk("idle_valid", 64'(bus_valid), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
